// File: rtl/count_checker.sv
// Sequence checker for a free-running counter: locks after LOCK_LEN in-order samples, tolerates one slip.
// Optional sticky_err output is enabled by defining COUNT_CHECKER_STICKY_EN.
module count_checker #(
    parameter int WIDTH    = 3,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_vld,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
`ifdef COUNT_CHECKER_STICKY_EN
    ,
    output logic             sticky_err
`endif
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        SYNC     = 2'b01,
        LOCKED   = 2'b10,
        SLIP     = 2'b11
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [3:0]       run;
    logic [3:0]       run_nxt;
    logic [WIDTH-1:0] exp_val;
    logic             match;
    logic             brk;
    logic             wrap;

    assign match = count_vld && (count_in == exp_val);
    assign state = cur;

    always_comb begin
        nxt     = cur;
        run_nxt = run;
        brk     = 1'b0;
        wrap    = 1'b0;
        if (count_vld) begin
            case (cur)
                UNLOCKED: begin
                    nxt     = SYNC;
                    run_nxt = 4'd1;
                end
                SYNC: begin
                    if (match) begin
                        run_nxt = run + 4'd1;
                        if (run + 4'd1 == 4'(LOCK_LEN)) nxt = LOCKED;
                    end else begin
                        run_nxt = 4'd1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        wrap = (count_in == '0);
                    end else begin
                        nxt = SLIP;
                        brk = 1'b1;
                    end
                end
                SLIP: begin
                    if (match) begin
                        nxt  = LOCKED;
                        wrap = (count_in == '0);
                    end else begin
                        nxt     = SYNC;
                        run_nxt = 4'd1;
                        brk     = 1'b1;
                    end
                end
                default: nxt = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= UNLOCKED;
            run        <= '0;
            exp_val    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            cur        <= nxt;
            run        <= run_nxt;
            locked     <= (nxt == LOCKED);
            err_pulse  <= brk;
            wrap_pulse <= wrap;
            if (count_vld) exp_val <= count_in + WIDTH'(1);
        end
    end

    // Clear beats a simultaneous break; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (brk && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

`ifdef COUNT_CHECKER_STICKY_EN
    // A new break wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_err <= 1'b0;
        end else if (brk) begin
            sticky_err <= 1'b1;
        end else if (clr_err) begin
            sticky_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
- REQ-001 SHALL have parameter WIDTH, default 3: bit width of the observed count.
- REQ-002 SHALL have parameter LOCK_LEN, default 4: consecutive in-sequence samples needed to lock (legal range 2..15).
- REQ-003 SHALL have parameter ERR_W, default 8: error counter width.
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port count_in, input, WIDTH: sampled counter value.
- REQ-007 SHALL have port count_vld, input, 1: count_in is valid this cycle.
- REQ-008 SHALL have port clr_err, input, 1: synchronous clear of the error counter.
- REQ-009 SHALL have port locked, output, 1: checker is in LOCKED.
- REQ-010 SHALL have port err_pulse, output, 1: one-cycle flag for a sequence break while locked.
- REQ-011 SHALL have port wrap_pulse, output, 1: one-cycle flag for an in-sequence wrap from 2^WIDTH-1 to 0.
- REQ-012 SHALL have port err_cnt, output, ERR_W: saturating count of sequence breaks.
- REQ-013 SHALL have port state, output, 2: FSM state encoding.

Function
- REQ-014 SHALL use four FSM states: UNLOCKED=00, SYNC=01, LOCKED=10, SLIP=11.
- REQ-015 SHALL hold an expected register exp; on every valid sample it SHALL load exp = count_in+1 mod 2^WIDTH, in all states.
- REQ-016 SHALL treat a sample as a match when count_vld=1 and count_in==exp.
- REQ-017 In UNLOCKED, a valid sample SHALL move the FSM to SYNC with run=1.
- REQ-018 In SYNC, a match SHALL increment run; when run reaches LOCK_LEN the FSM SHALL go to LOCKED.
- REQ-019 In SYNC, a mismatch SHALL set run=1 and the FSM SHALL stay in SYNC.
- REQ-020 In LOCKED, a match SHALL keep LOCKED.
- REQ-021 In LOCKED, a mismatch SHALL go to SLIP, pulse err_pulse, and increment err_cnt.
- REQ-022 In SLIP, a match SHALL return the FSM to LOCKED; this tolerates a single slip.
- REQ-023 In SLIP, a mismatch SHALL go to SYNC with run=1, pulse err_pulse, and increment err_cnt.
- REQ-024 When count_vld=0, SHALL change no state, run, or exp, and SHALL assert no pulses.
- REQ-025 All outputs SHALL be registered, appearing the cycle after the sample edge (latency 1).
- REQ-026 locked SHALL be 1 only in LOCKED; it SHALL be 0 in SLIP.
- REQ-027 wrap_pulse SHALL assert only for a match in LOCKED or SLIP with count_in==0.
- REQ-028 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
- REQ-029 clr_err SHALL take priority over a simultaneous increment: err_cnt becomes 0 and that error is not counted.
- REQ-030 A repeated value (count_in==exp-1) SHALL be treated as a mismatch.

Reset
- REQ-031 While rst=0, SHALL immediately force: state=UNLOCKED, run=0, exp=0, locked=0, err_pulse=0, wrap_pulse=0, err_cnt=0.
- REQ-032 Reset mid-operation SHALL discard lock; lock is reacquired only after a fresh LOCK_LEN run.

Configuration
- REQ-033 With COUNT_CHECKER_STICKY_EN defined, SHALL add output sticky_err (1 bit), set on any err_pulse, cleared only by clr_err or reset.
- REQ-034 If clr_err and a new error occur in the same cycle, sticky_err SHALL be 1 (set wins).
- REQ-035 Without COUNT_CHECKER_STICKY_EN, the sticky_err port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-036 Bench SHALL cover lock: rst release, count_vld=1, count_in=0,1,2,3 -> locked=1 one cycle after the sample 3, state=10.
- REQ-037 Bench SHALL cover wrap: locked, count_in=6,7,0 -> wrap_pulse=1 for exactly one cycle after the 0, err_cnt unchanged.
- REQ-038 Bench SHALL cover single slip: locked at 3, count_in=5,6 -> err_pulse once, err_cnt=1, state=11 then 10, locked 0 for one cycle.
- REQ-039 Bench SHALL cover double slip: locked at 2, count_in=5,1 -> err_cnt=2, state=01, locked=0; count_in=2,3,4 -> relock.
- REQ-040 Bench SHALL cover count_vld gaps and a clr_err collision: gaps of 3 idle cycles inside a locked run -> no error; clr_err asserted with a mismatch -> err_cnt=0.
- REQ-041 Bench SHALL cover reset and saturation: rst pulsed low mid-LOCKED -> all outputs 0 asynchronously; ERR_W=2 with 5 breaks -> err_cnt=3.
